eco32f_bus_arbiter: RTL and testbench

ECO32F_BUS_ARBITER -- requirements
Module: eco32f_bus_arbiter

---
 rtl/eco32f_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_eco32f_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/eco32f_bus_arbiter.sv
// Two-requester (fetch I, LSU D) Wishbone arbiter with registered grant and stalled-strobe timeout.
// Optional macro ECO32F_ARB_ROUND_ROBIN_EN: alternate winner on simultaneous requests (default: D wins).
module eco32f_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwbm_adr_i,
  input  logic        iwbm_cyc_i,
  input  logic        iwbm_stb_i,
  input  logic        iwbm_we_i,
  input  logic [3:0]  iwbm_sel_i,
  input  logic [2:0]  iwbm_cti_i,
  input  logic [1:0]  iwbm_bte_i,
  input  logic [31:0] iwbm_dat_i,
  output logic        iwbm_ack_o,
  output logic        iwbm_err_o,
  output logic        iwbm_rty_o,
  output logic [31:0] iwbm_dat_o,
  input  logic [31:0] dwbm_adr_i,
  input  logic        dwbm_cyc_i,
  input  logic        dwbm_stb_i,
  input  logic        dwbm_we_i,
  input  logic [3:0]  dwbm_sel_i,
  input  logic [2:0]  dwbm_cti_i,
  input  logic [1:0]  dwbm_bte_i,
  input  logic [31:0] dwbm_dat_i,
  output logic        dwbm_ack_o,
  output logic        dwbm_err_o,
  output logic        dwbm_rty_o,
  output logic [31:0] dwbm_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [9:0] to_cnt;
  logic       gnt_i;
  logic       gnt_d;
  logic       d_wins;
  logic       granted_stb;
  logic       any_resp;
  logic       to_hit;

  assign gnt_i       = (state == GNT_I);
  assign gnt_d       = (state == GNT_D);
  assign granted_stb = (gnt_i & iwbm_stb_i) | (gnt_d & dwbm_stb_i);
  assign any_resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // The stall counter holds the stalled cycles already seen, so the hit lands on the N-th one.
  assign to_hit      = granted_stb & ~any_resp & (to_cnt == TO_LAST);

`ifdef ECO32F_ARB_ROUND_ROBIN_EN
  logic last_d;

  assign d_wins = ~last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_d <= (state_nxt == GNT_D);
    end
  end
`else
  assign d_wins = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dwbm_cyc_i && (!iwbm_cyc_i || d_wins)) state_nxt = GNT_D;
        else if (iwbm_cyc_i)                       state_nxt = GNT_I;
        else                                       state_nxt = IDLE;
      end
      GNT_I:   if (!iwbm_cyc_i) state_nxt = IDLE;
      GNT_D:   if (!dwbm_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!granted_stb || any_resp || to_hit) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 10'd1;
    end
  end

  assign wbm_adr_o = gnt_d ? dwbm_adr_i : iwbm_adr_i;
  assign wbm_sel_o = gnt_d ? dwbm_sel_i : iwbm_sel_i;
  assign wbm_cti_o = gnt_d ? dwbm_cti_i : iwbm_cti_i;
  assign wbm_bte_o = gnt_d ? dwbm_bte_i : iwbm_bte_i;
  assign wbm_dat_o = gnt_d ? dwbm_dat_i : iwbm_dat_i;
  assign wbm_cyc_o = (gnt_i & iwbm_cyc_i) | (gnt_d & dwbm_cyc_i);
  assign wbm_we_o  = (gnt_i & iwbm_we_i)  | (gnt_d & dwbm_we_i);
  assign wbm_stb_o = granted_stb & ~to_hit;

  assign iwbm_ack_o = gnt_i & wbm_ack_i;
  assign iwbm_err_o = gnt_i & (wbm_err_i | to_hit);
  assign iwbm_rty_o = gnt_i & wbm_rty_i;
  assign dwbm_ack_o = gnt_d & wbm_ack_i;
  assign dwbm_err_o = gnt_d & (wbm_err_i | to_hit);
  assign dwbm_rty_o = gnt_d & wbm_rty_i;
  assign iwbm_dat_o = wbm_dat_i;
  assign dwbm_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_eco32f_bus_arbiter.sv
// Directed bench for eco32f_bus_arbiter: grant order, response routing, bursts, timeout and reset abort.
module tb_eco32f_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iadr, dadr, idat, ddat, wbm_dat_i, iwbm_dat_o, dwbm_dat_o, wbm_adr_o, wbm_dat_o;
  logic        icyc, istb, iwe, dcyc, dstb, dwe;
  logic [3:0]  isel, dsel, wbm_sel_o;
  logic [2:0]  icti, dcti, wbm_cti_o;
  logic [1:0]  ibte, dbte, wbm_bte_o;
  logic        iwbm_ack_o, iwbm_err_o, iwbm_rty_o, dwbm_ack_o, dwbm_err_o, dwbm_rty_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  int checks   = 0;
  int failures = 0;
  int ia, da;

  eco32f_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .iwbm_adr_i(iadr), .iwbm_cyc_i(icyc), .iwbm_stb_i(istb), .iwbm_we_i(iwe),
    .iwbm_sel_i(isel), .iwbm_cti_i(icti), .iwbm_bte_i(ibte), .iwbm_dat_i(idat),
    .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o), .iwbm_rty_o(iwbm_rty_o), .iwbm_dat_o(iwbm_dat_o),
    .dwbm_adr_i(dadr), .dwbm_cyc_i(dcyc), .dwbm_stb_i(dstb), .dwbm_we_i(dwe),
    .dwbm_sel_i(dsel), .dwbm_cti_i(dcti), .dwbm_bte_i(dbte), .dwbm_dat_i(ddat),
    .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o), .dwbm_rty_o(dwbm_rty_o), .dwbm_dat_o(dwbm_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iadr = '0; dadr = '0; idat = 32'h1111_0000; ddat = 32'h2222_0000; wbm_dat_i = '0;
    icyc = 0; istb = 0; iwe = 0; dcyc = 0; dstb = 0; dwe = 0;
    isel = 4'hF; dsel = 4'h3; icti = 0; dcti = 0; ibte = 0; dbte = 0;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    step(); step();
    rst = 1'b0;

    // Reset state, dropped response in IDLE, data broadcast
    step();
    wbm_ack_i = 1; wbm_dat_i = 32'hA5A5_5A5A;
    #1;
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("idle_iack", {31'd0, iwbm_ack_o}, 32'd0);
    chk("idle_dack", {31'd0, dwbm_ack_o}, 32'd0);
    chk("idat_bcast", iwbm_dat_o, 32'hA5A5_5A5A);
    chk("ddat_bcast", dwbm_dat_o, 32'hA5A5_5A5A);

    // Single I read, ack two cycles after grant
    step();
    wbm_ack_i = 0; icyc = 1; istb = 1; iadr = 32'h0000_1000;
    #1 chk("t1_idle_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    step(); #1;
    chk("t1_gnt_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("t1_adr", wbm_adr_o, 32'h0000_1000);
    chk("t1_dat_o", wbm_dat_o, 32'h1111_0000);
    step(); #1 chk("t1_wait_ack", {31'd0, iwbm_ack_o}, 32'd0);
    step(); wbm_ack_i = 1; #1;
    chk("t1_iack", {31'd0, iwbm_ack_o}, 32'd1);
    chk("t1_dack", {31'd0, dwbm_ack_o}, 32'd0);
    step(); wbm_ack_i = 0; icyc = 0; istb = 0; #1;
    chk("t1_ack_once", {31'd0, iwbm_ack_o}, 32'd0);
    step(); #1 chk("t1_idle", {31'd0, wbm_cyc_o}, 32'd0);

    // Simultaneous requests: D first, I two cycles after D drops
    step();
    icyc = 1; istb = 1; dcyc = 1; dstb = 1; dadr = 32'h0000_2000; dwe = 1;
    step(); #1;
    chk("t2_d_first", wbm_adr_o, 32'h0000_2000);
    chk("t2_we", {31'd0, wbm_we_o}, 32'd1);
    step(); wbm_ack_i = 1; #1;
    chk("t2_dack", {31'd0, dwbm_ack_o}, 32'd1);
    chk("t2_iack", {31'd0, iwbm_ack_o}, 32'd0);
    step(); wbm_ack_i = 0; dcyc = 0; dstb = 0; dwe = 0; #1;
    chk("t2_drop_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    step(); #1 chk("t2_dead", {31'd0, wbm_cyc_o}, 32'd0);
    step(); #1;
    chk("t2_i_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("t2_i_adr", wbm_adr_o, 32'h0000_1000);
    step(); wbm_ack_i = 1; #1 chk("t2_i_ack", {31'd0, iwbm_ack_o}, 32'd1);
    step(); wbm_ack_i = 0; icyc = 0; istb = 0;
    step();
    // D alone, then both again: winner depends on arbitration mode
    dcyc = 1; dstb = 1;
    step(); wbm_ack_i = 1; #1 chk("t2_dalone_ack", {31'd0, dwbm_ack_o}, 32'd1);
    step(); wbm_ack_i = 0; dcyc = 0; dstb = 0;
    step();
    icyc = 1; istb = 1; dcyc = 1; dstb = 1;
    step(); #1;
`ifdef ECO32F_ARB_ROUND_ROBIN_EN
    chk("t2_repeat_winner", wbm_adr_o, 32'h0000_1000);
`else
    chk("t2_repeat_winner", wbm_adr_o, 32'h0000_2000);
`endif
    step(); icyc = 0; istb = 0; dcyc = 0; dstb = 0;
    step();

    // I 8-beat burst with a stb gap; D requests mid-burst
    icyc = 1; istb = 1; icti = 3'b010; iadr = 32'h0000_3000;
    step();
    ia = 0; da = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        istb = 0; wbm_ack_i = 0; #1;
        chk("t3_gap_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("t3_gap_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        chk("t3_gap_adr", wbm_adr_o, 32'h0000_3000);
        step();
        istb = 1;
      end
      icti = (b == 7) ? 3'b111 : 3'b010;
      wbm_ack_i = 1;
      if (b == 2) begin
        dcyc = 1; dstb = 1; dadr = 32'h0000_4000;
      end
      #1;
      ia += int'(iwbm_ack_o);
      da += int'(dwbm_ack_o);
      step();
    end
    wbm_ack_i = 0; icyc = 0; istb = 0; icti = 0; #1;
    chk("t3_i_acks", 32'(ia), 32'd8);
    chk("t3_d_acks", 32'(da), 32'd0);
    chk("t3_drop_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    step(); #1 chk("t3_dead", {31'd0, wbm_cyc_o}, 32'd0);
    step(); #1;
    chk("t3_d_gnt", wbm_adr_o, 32'h0000_4000);
    chk("t4_s1_err", {31'd0, dwbm_err_o}, 32'd0);

    // Timeout on stalled D strobe (TIMEOUT_CYCLES = 8)
    for (int k = 2; k <= 7; k++) step();
    #1 chk("t4_s7_err", {31'd0, dwbm_err_o}, 32'd0);
    step(); #1;
    chk("t4_s8_err", {31'd0, dwbm_err_o}, 32'd1);
    chk("t4_s8_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("t4_s8_ierr", {31'd0, iwbm_err_o}, 32'd0);
    step(); #1;
    chk("t4_s9_err", {31'd0, dwbm_err_o}, 32'd0);
    chk("t4_s9_stb", {31'd0, wbm_stb_o}, 32'd1);
    for (int k = 10; k <= 15; k++) step();
    #1 chk("t4_s15_err", {31'd0, dwbm_err_o}, 32'd0);
    step(); #1 chk("t4_s16_err", {31'd0, dwbm_err_o}, 32'd1);
    for (int k = 17; k <= 24; k++) step();
    wbm_ack_i = 1; #1;
    chk("t4_ack_wins_ack", {31'd0, dwbm_ack_o}, 32'd1);
    chk("t4_ack_wins_err", {31'd0, dwbm_err_o}, 32'd0);
    chk("t4_ack_wins_stb", {31'd0, wbm_stb_o}, 32'd1);
    step(); wbm_ack_i = 0; #1 chk("t4_after_ack_err", {31'd0, dwbm_err_o}, 32'd0);

    // Reset during GNT_D aborts the grant without an error
    step(); rst = 1; #1 chk("t5_pre_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    step(); #1;
    chk("t5_abort_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("t5_abort_err", {31'd0, dwbm_err_o}, 32'd0);
    chk("t5_abort_stb", {31'd0, wbm_stb_o}, 32'd0);
    rst = 0; dcyc = 0; dstb = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
